// File: rtl/yalu_core_pkg.sv
// rtl/yalu_core_pkg.sv - shared width and opcode constants for the yalu_core ALU
package yalu_core_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } op_e;

endpackage

// File: rtl/yalu_core_if.sv
// rtl/yalu_core_if.sv - operand/result bundle for the yalu_core ALU
interface yalu_core_if #(
  parameter int WIDTH = yalu_core_pkg::WIDTH
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic [WIDTH-1:0] z;
  logic             ex;
  logic             v_sticky;

  modport master (output a, b, op, input z, ex, v_sticky);
  modport slave  (input a, b, op, output z, ex, v_sticky);
endinterface

// File: rtl/yalu_core_arith.sv
// rtl/yalu_core_arith.sv - shared adder/subtractor; subtraction is a + ~b + 1
module yalu_core_arith #(
  parameter int WIDTH = yalu_core_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;

  assign b_eff       = sub ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  // Overflow judged on the actual adder inputs, so it covers both add and subtract.
  assign ovf         = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/yalu_core.sv
// rtl/yalu_core.sv - combinational ALU with zero flag and a sticky signed-overflow register
module yalu_core
  import yalu_core_pkg::*;
#(
  parameter int WIDTH = yalu_core_pkg::WIDTH
) (
  output logic [WIDTH-1:0] z,
  output logic             ex,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             clk,
  input  logic             reset,
  output logic             v_sticky
);

  logic [WIDTH-1:0] sum;
  logic             carry_unused;
  logic             arith_ovf;
  logic             sub;
  logic             slt;
  logic             ovf;
  logic             sticky_q = 1'b0;

  // SLT reuses the subtract path.
  assign sub = (op == OP_SUB) || (op == OP_SLT);

  yalu_core_arith #(.WIDTH(WIDTH)) u_arith (
    .a    (a),
    .b    (b),
    .sub  (sub),
    .sum  (sum),
    .cout (carry_unused),
    .ovf  (arith_ovf)
  );

  // Sign xor overflow gives the true signed less-than even when a - b wraps.
  assign slt = sum[WIDTH-1] ^ arith_ovf;
  assign ovf = arith_ovf && ((op == OP_ADD) || (op == OP_SUB));

  always_comb begin
    z = '0;
    case (op)
      OP_AND:  z = a & b;
      OP_OR:   z = a | b;
      OP_ADD:  z = sum;
      OP_SUB:  z = sum;
      OP_SLT:  z = {{(WIDTH-1){1'b0}}, slt};
      default: z = '0;
    endcase
  end

  assign ex = (z == '0);

  always_ff @(posedge clk) begin
    if (reset) sticky_q <= 1'b0;
    else       sticky_q <= sticky_q | ovf;
  end

  assign v_sticky = sticky_q;

endmodule

// File: tb/tb_yalu_core.sv
// tb/tb_yalu_core.sv - self-checking bench for yalu_core against a signed arithmetic model
module tb_yalu_core;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   passes = 0;
  logic m_sticky = 1'b0;

  yalu_core_if bus ();

  yalu_core u_dut (
    .z        (bus.z),
    .ex       (bus.ex),
    .a        (bus.a),
    .b        (bus.b),
    .op       (bus.op),
    .clk      (clk),
    .reset    (reset),
    .v_sticky (bus.v_sticky)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_z(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      3'b000:  return x & y;
      3'b001:  return x | y;
      3'b010:  return x + y;
      3'b110:  return x - y;
      3'b111:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint r;
    if (o == 3'b010)      r = longint'($signed(x)) + longint'($signed(y));
    else if (o == 3'b110) r = longint'($signed(x)) - longint'($signed(y));
    else                  return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic apply(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
    logic [31:0] ez;
    bus.op = o;
    bus.a  = x;
    bus.b  = y;
    #1;
    ez = ref_z(o, x, y);
    chk({tag, ".z"}, bus.z, ez);
    chk({tag, ".ex"}, {31'd0, bus.ex}, {31'd0, (ez == 32'd0)});
  endtask

  task automatic tick(input string tag);
    logic o;
    o = ref_ovf(bus.op, bus.a, bus.b);
    @(posedge clk);
    if (reset) m_sticky = 1'b0;
    else       m_sticky = m_sticky | o;
    #1;
    chk({tag, ".v_sticky"}, {31'd0, bus.v_sticky}, {31'd0, m_sticky});
  endtask

  initial begin
    logic [2:0]  ops [5];
    logic [31:0] ra, rb;
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b110; ops[4] = 3'b111;
    bus.a = '0; bus.b = '0; bus.op = 3'b000;
    #1;
    chk("powerup", {31'd0, bus.v_sticky}, 32'd0);

    reset = 1'b1;
    tick("reset");
    reset = 1'b0;

    apply(3'b000, 32'hF0F0F0F0, 32'h0FF00FF0, "and");
    chk("and.const", bus.z, 32'h00F000F0);
    apply(3'b001, 32'hF0F0F0F0, 32'h0FF00FF0, "or");
    chk("or.const", bus.z, 32'hFFF0FFF0);

    apply(3'b110, 32'd5, 32'd5, "sub_zero");
    chk("sub_zero.ex1", {31'd0, bus.ex}, 32'd1);
    tick("sub_zero");

    apply(3'b111, 32'h80000000, 32'd1, "slt_min");
    chk("slt_min.const", bus.z, 32'd1);
    tick("slt_min");
    apply(3'b111, 32'd1, 32'hFFFFFFFF, "slt_neg");
    chk("slt_neg.const", bus.z, 32'd0);
    apply(3'b111, 32'd7, 32'd7, "slt_eq");
    apply(3'b111, 32'h7FFFFFFF, 32'h80000000, "slt_ovf");
    tick("slt_ovf_no_sticky");

    apply(3'b101, 32'h7FFFFFFF, 32'h7FFFFFFF, "rsvd101");
    apply(3'b011, 32'hFFFFFFFF, 32'h12345678, "rsvd011");
    apply(3'b100, 32'h80000000, 32'h80000000, "rsvd100");
    tick("rsvd_no_sticky");

    apply(3'b010, 32'h7FFFFFFF, 32'd1, "add_ovf");
    chk("add_ovf.const", bus.z, 32'h80000000);
    tick("add_ovf");
    chk("add_ovf.set", {31'd0, bus.v_sticky}, 32'd1);
    apply(3'b000, 32'd0, 32'd0, "hold");
    tick("hold");

    reset = 1'b1;
    apply(3'b010, 32'h80000000, 32'h80000000, "rst_add");
    tick("rst_prio");
    chk("rst_prio.clr", {31'd0, bus.v_sticky}, 32'd0);
    reset = 1'b0;

    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 12; i++) begin
        ra = $urandom;
        rb = $urandom;
        if (i == 0) rb = ra;
        if (i == 1) begin ra = 32'h80000000; rb = 32'h7FFFFFFF; end
        apply(ops[k], ra, rb, $sformatf("rand_op%0d_%0d", ops[k], i));
        if (i % 4 == 3) tick($sformatf("rand_op%0d_%0d", ops[k], i));
      end
      reset = 1'b1;
      tick($sformatf("rand_rst%0d", k));
      reset = 1'b0;
    end

    for (int i = 0; i < 4; i++) begin
      apply(3'b101, $urandom, $urandom, $sformatf("rand_rsvd_%0d", i));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
